mdu_iterative: RTL and testbench

//  Multi-cycle multiply/divide unit for the EX stage. Executes MULT/MULTU/DIV/DIVU
//  (decoded upstream from alucontrol into a 2-bit op) and produces HI/LO results.

---
 rtl/mdu_iterative.sv | 214 +++++++++++++++++++++
 tb/tb_mdu_iterative.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// mdu_iterative
//   Multi-cycle multiply/divide unit for the EX stage. It executes
//   MULT/MULTU/DIV/DIVU and returns HI/LO. The datapath is radix-2
//   iterative and handles one bit per cycle. The unit uses a
//   start/busy/valid handshake and honours a pipeline-flush cancel.
//
//   Ports
//     clk           rising-edge clock
//     rst           synchronous active-high reset
//     start         request, sampled only while idle
//     op            00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     a, b          multiplicand/dividend (rs), multiplier/divisor (rt)
//     cancel        flush: abort the operation in flight, write nothing
//     busy          high while an operation is in flight (pipeline stall)
//     result_valid  one-cycle pulse; hi/lo are updated on the same edge
//     hi, lo        product[2W-1:W]/product[W-1:0] or remainder/quotient
//
//   Configuration macro: MDU_FAST_MUL_EN
//     Defined   : MULT/MULTU use a single-cycle multiplier and complete
//                 one cycle after start. Divide stays iterative.
//     Undefined : every op is iterative with latency WIDTH+1, and no
//                 multiplier is inferred.
module mdu_iterative #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             is_div;     // latched op[1]
  logic             neg_q;      // product / quotient needs negation
  logic             neg_r;      // remainder takes the dividend's sign
  logic             div_zero;   // divisor was zero at start
  logic [WIDTH-1:0] a_raw;      // raw dividend, returned on divide-by-zero
  logic [WIDTH-1:0] opnd;       // |multiplicand| or |divisor|

  // Shared working register:
  //   multiply: [2W:W] running partial sum, [W-1:0] multiplier bits
  //             that are still unconsumed.
  //   divide:   [2W:W] partial remainder, [W-1:0] dividend bits
  //             shifting out while quotient bits shift in.
  logic [2*WIDTH:0] p, p_step;

  // Operand decode at the accept edge
  logic             sgn_in, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    sgn_in = ~op[0];
    a_neg  = sgn_in & a[WIDTH-1];
    b_neg  = sgn_in & b[WIDTH-1];
    a_abs  = a_neg ? -a : a;
    b_abs  = b_neg ? -b : b;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] ax, bx, fprod;

  // Low 2W bits of the product do not depend on signedness once the
  // operands are extended to 2W bits.
  always_comb begin
    ax    = {{WIDTH{a_neg}}, a};
    bx    = {{WIDTH{b_neg}}, b};
    fprod = ax * bx;
  end
`endif

  // One iteration step
  logic [WIDTH:0] mul_sum, rem_sh, rem_sub;

  always_comb begin
    mul_sum = '0;
    rem_sh  = '0;
    rem_sub = '0;
    p_step  = p;
    if (!is_div) begin
      // p[2W] is always zero before the add; it is kept for a uniform width.
      mul_sum = p[2*WIDTH:WIDTH] + (p[0] ? {1'b0, opnd} : '0);
      p_step  = {1'b0, mul_sum, p[WIDTH-1:1]};
    end else begin
      rem_sh  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, opnd};
      if (rem_sh >= {1'b0, opnd})
        p_step = {rem_sub, p[WIDTH-2:0], 1'b1};
      else
        p_step = {rem_sh, p[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fixup and selection of the result
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt;

  always_comb begin
    prod_fix = neg_q ? -p[2*WIDTH-1:0] : p[2*WIDTH-1:0];
    quo_fix  = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    rem_fix  = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      hi_nxt = prod_fix[2*WIDTH-1:WIDTH];
      lo_nxt = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      hi_nxt = a_raw;
      lo_nxt = '1;
    end else begin
      hi_nxt = rem_fix;
      lo_nxt = quo_fix;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
`ifdef MDU_FAST_MUL_EN
          state_nxt = op[1] ? RUN : FIX;
`else
          state_nxt = RUN;
`endif
        end
        RUN:     if (cnt == CW'(1)) state_nxt = FIX;
        FIX:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy = (state == RUN) || (state == FIX);
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      is_div       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      a_raw        <= '0;
      opnd         <= '0;
      p            <= '0;
      hi           <= '0;
      lo           <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (!cancel) begin
        case (state)
          IDLE: if (start) begin
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (b == '0);
            a_raw    <= a;
            cnt      <= CW'(WIDTH);
            opnd     <= op[1] ? b_abs : a_abs;
            p        <= {{(WIDTH+1){1'b0}}, (op[1] ? a_abs : b_abs)};
`ifdef MDU_FAST_MUL_EN
            // The product is already signed, so the fixup must leave it alone.
            if (!op[1]) begin
              p     <= {1'b0, fprod};
              neg_q <= 1'b0;
              cnt   <= '0;
            end
`endif
          end
          RUN: begin
            p   <= p_step;
            cnt <= cnt - CW'(1);
          end
          FIX: begin
            hi           <= hi_nxt;
            lo           <= lo_nxt;
            result_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, cancel, busy, result_valid;
  logic [1:0]   op;
  logic [W-1:0] a, b, hi, lo;

  int ncomp = 0;
  int nfail = 0;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  mdu_iterative #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .result_valid(result_valid),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input logic [1:0] o);
    return (FAST && !o[1]) ? 1 : W + 1;
  endfunction

  // Reference model: plain 64-bit arithmetic, {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: begin sp = sx * sy; return sp; end
      2'b01: return ux * uy;
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ncomp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Present a request at a non-edge time, then let it be sampled at E0.
  // Start may be held for `hold` extra edges with scrambled operands.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int hold, output int spent, output int nbusy);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    spent = 0; nbusy = 0;
    for (int i = 0; i < hold; i++) begin
      a = $urandom; b = $urandom; op = 2'($urandom);
      if (busy) nbusy++;
      @(posedge clk); #1;
      spent++;
    end
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  task automatic collect(input string nm, input logic [63:0] exp, input int lat,
                         input int n0, input int nb0);
    int n, nb;
    n = n0; nb = nb0;
    while (!result_valid && n < 200) begin
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, ".latency"}, 64'(n), 64'(lat));
    chk({nm, ".busy_cycles"}, 64'(nb), 64'(lat));
    chk({nm, ".busy_in_valid"}, 64'(busy), 64'd0);
    chk({nm, ".hilo"}, {hi, lo}, exp);
  endtask

  task automatic watch(input string nm, input int cycles, input logic [63:0] keep);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (result_valid) pulses++;
    end
    chk({nm, ".no_valid"}, 64'(pulses), 64'd0);
    chk({nm, ".hilo_held"}, {hi, lo}, keep);
  endtask

  typedef struct {
    string        nm;
    logic [1:0]   o;
    logic [31:0]  x, y, ehi, elo;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int sp, nb;
    logic [63:0] prior;

    tbl[0] = '{"mult_neg",   2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[1] = '{"divu_100_7", 2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    tbl[2] = '{"div_m7_2",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{"div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[4] = '{"div_by0",    2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    tbl[5] = '{"multu_max",  2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    tbl[6] = '{"divu_by0",   2'b11, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    tbl[7] = '{"mult_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[8] = '{"div_7_m2",   2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy",  64'(busy), 64'd0);
    chk("reset.valid", 64'(result_valid), 64'd0);
    chk("reset.hilo",  {hi, lo}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      launch(tbl[i].o, tbl[i].x, tbl[i].y, 0, sp, nb);
      collect(tbl[i].nm, {tbl[i].ehi, tbl[i].elo}, lat_of(tbl[i].o), sp, nb);
      @(posedge clk); #1;
    end

    // Back-to-back: the next start is issued in the valid cycle
    launch(2'b00, 32'hFFFF_FFFE, 32'd3, 0, sp, nb);
    collect("b2b_first", 64'hFFFF_FFFF_FFFF_FFFA, lat_of(2'b00), sp, nb);
    launch(2'b01, 32'hFFFF_FFFF, 32'd2, 0, sp, nb);
    collect("b2b_second", 64'h0000_0001_FFFF_FFFE, lat_of(2'b01), sp, nb);

    // Cancel during RUN
    @(posedge clk); #1;
    prior = {hi, lo};
    launch(2'b11, 32'd1000, 32'd3, 0, sp, nb);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_run.busy", 64'(busy), 64'd0);
    watch("cancel_run", 45, prior);

    // Cancel during FIX suppresses the write
    launch(2'b11, 32'd1000, 32'd3, 0, sp, nb);
    repeat (W) @(posedge clk);
    #1;
    chk("cancel_fix.busy_before", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_fix.valid", 64'(result_valid), 64'd0);
    chk("cancel_fix.busy",  64'(busy), 64'd0);
    watch("cancel_fix", 5, prior);

    // Cancel together with start while idle: start ignored
    cancel = 1'b1; start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd2;
    @(posedge clk); #1;
    cancel = 1'b0; start = 1'b0;
    chk("cancel_start.busy", 64'(busy), 64'd0);
    watch("cancel_start", 40, prior);

    // Start held (operands scrambled) while busy: one op only, original operands
    launch(2'b11, 32'd100, 32'd7, 20, sp, nb);
    collect("start_held", 64'h0000_0002_0000_000E, W + 1, sp, nb);
    watch("start_held_after", 40, 64'h0000_0002_0000_000E);

    // Reset in the middle of a divide
    launch(2'b10, 32'd1000, 32'd7, 0, sp, nb);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid.busy",  64'(busy), 64'd0);
    chk("rst_mid.valid", 64'(result_valid), 64'd0);
    chk("rst_mid.hilo",  {hi, lo}, 64'd0);
    watch("rst_mid", 40, 64'd0);

    // Randomised operations against the arithmetic model
    for (int k = 0; k < 150; k++) begin
      logic [1:0]  ro;
      logic [31:0] rx, ry;
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = '0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = 32'($urandom_range(1, 15));
        3: rx = 32'($urandom_range(0, 15));
        default: ;
      endcase
      launch(ro, rx, ry, 0, sp, nb);
      collect($sformatf("rand%0d_op%0d", k, ro), model(ro, rx, ry), lat_of(ro), sp, nb);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
